// File: rtl/servo_pkg.sv
// Shared definitions for the servo encode/decode path. The scale constants
// live here so the PWM encoder and this decoder always agree on the mapping.
package servo_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2
  } servo_state_e;

  // 1 ms of high time at 100 MHz maps to code 0
  localparam int unsigned SERVO_PULSE_MIN = 100000;
  // 1 ms / 255, truncated: clocks per code LSB
  localparam int unsigned SERVO_STEP_CLKS = 392;
  localparam logic [7:0]  SERVO_CODE_MAX  = 8'd255;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus a history flop for
// edge detection. The chain resets to 1 so that a pin already high at reset
// release is not seen as a fresh rising edge.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;

  // Metastability chain (s1, s2) and previous-sample register (s3)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~s3_q;
  assign fall_o  = ~s2_q & s3_q;

endmodule

// File: rtl/pwm_to_servo.sv
// Hobby-servo PWM decoder: measures the high time of each frame and turns
// it back into the 8-bit position code, with glitch/over-length strobes and
// a signal-present flag driven by a frame timeout.
//
// state | meaning
// SYNC  | wait for the line to be low so a partial pulse is never measured
// ARM   | line low, waiting for a rising edge
// HIGH  | measuring a pulse; hi_cnt counts high clocks, code_cnt accumulates
module pwm_to_servo
  import servo_pkg::*;
#(
  parameter int unsigned PULSE_MIN     = SERVO_PULSE_MIN,
  parameter int unsigned STEP_CLKS     = SERVO_STEP_CLKS,
  parameter int unsigned PULSE_MAX     = 250000,
  parameter int unsigned GLITCH_CLKS   = 50000,
  parameter int unsigned FRAME_TIMEOUT = 3000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_in,
  output logic [7:0] servo_val,
  output logic       valid,
  output logic       err_long,
  output logic       err_glitch,
  output logic       signal_ok
);

  localparam int HI_W  = $clog2(PULSE_MAX + 1);
  localparam int FR_W  = $clog2(FRAME_TIMEOUT + 1);
  localparam int PRE_W = (STEP_CLKS > 2) ? $clog2(STEP_CLKS) : 1;

  localparam logic [HI_W-1:0]  MIN_C      = HI_W'(PULSE_MIN);
  localparam logic [HI_W-1:0]  MAX_C      = HI_W'(PULSE_MAX);
  localparam logic [HI_W-1:0]  GLITCH_C   = HI_W'(GLITCH_CLKS);
  localparam logic [FR_W-1:0]  TIMEOUT_C  = FR_W'(FRAME_TIMEOUT);
  localparam logic [PRE_W-1:0] PRE_INIT_C = PRE_W'(STEP_CLKS / 2);
  localparam logic [PRE_W-1:0] PRE_LAST_C = PRE_W'(STEP_CLKS - 1);

  logic level, rise, fall;

  servo_state_e     state_q, state_d;
  logic [HI_W-1:0]  hi_cnt_q, hi_cnt_d;
  logic [PRE_W-1:0] step_pre_q, step_pre_d;
  logic [7:0]       code_cnt_q, code_cnt_d;
  logic [FR_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]       servo_val_q, servo_val_d;
  logic             valid_q, valid_d;
  logic             err_long_q, err_long_d;
  logic             err_glitch_q, err_glitch_d;
  logic             signal_ok_q, signal_ok_d;

  sync_edge u_sync (
    .clk     (clk),
    .rst     (rst),
    .d_i     (pwm_in),
    .level_o (level),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= SYNC;
      hi_cnt_q     <= '0;
      step_pre_q   <= '0;
      code_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      servo_val_q  <= '0;
      valid_q      <= 1'b0;
      err_long_q   <= 1'b0;
      err_glitch_q <= 1'b0;
      signal_ok_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_cnt_q     <= hi_cnt_d;
      step_pre_q   <= step_pre_d;
      code_cnt_q   <= code_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      servo_val_q  <= servo_val_d;
      valid_q      <= valid_d;
      err_long_q   <= err_long_d;
      err_glitch_q <= err_glitch_d;
      signal_ok_q  <= signal_ok_d;
    end
  end

  // Pulse measurement FSM: next state, counters and strobes
  always_comb begin
    state_d      = state_q;
    hi_cnt_d     = hi_cnt_q;
    step_pre_d   = step_pre_q;
    code_cnt_d   = code_cnt_q;
    servo_val_d  = servo_val_q;
    valid_d      = 1'b0;
    err_long_d   = 1'b0;
    err_glitch_d = 1'b0;
    case (state_q)
      SYNC: begin
        if (!level) state_d = ARM;
      end
      ARM: begin
        if (rise) begin
          // The rise cycle is itself the first high clock, so hi_cnt equals
          // the pulse width when the fall is seen.
          hi_cnt_d   = HI_W'(1);
          step_pre_d = PRE_INIT_C;
          code_cnt_d = '0;
          state_d    = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          if (hi_cnt_q < GLITCH_C) begin
            err_glitch_d = 1'b1;
          end else begin
            servo_val_d = code_cnt_q;
            valid_d     = 1'b1;
          end
          state_d = ARM;
        end else if (hi_cnt_q >= MAX_C) begin
          err_long_d = 1'b1;
          state_d    = SYNC;
        end else begin
          hi_cnt_d = hi_cnt_q + HI_W'(1);
          // Prescaler starts half a step in, giving round-to-nearest codes
          if (hi_cnt_q >= MIN_C) begin
            if (step_pre_q == PRE_LAST_C) begin
              step_pre_d = '0;
              if (code_cnt_q != SERVO_CODE_MAX) code_cnt_d = code_cnt_q + 8'd1;
            end else begin
              step_pre_d = step_pre_q + PRE_W'(1);
            end
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // Frame timeout and signal health; a rise in the timeout cycle wins
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    signal_ok_d = signal_ok_q;
    if (rise) begin
      frame_cnt_d = '0;
    end else if (frame_cnt_q != TIMEOUT_C) begin
      frame_cnt_d = frame_cnt_q + FR_W'(1);
    end
    if (valid_d) begin
      signal_ok_d = 1'b1;
    end else if (!rise && frame_cnt_q == TIMEOUT_C) begin
      signal_ok_d = 1'b0;
    end
  end

  assign servo_val  = servo_val_q;
  assign valid      = valid_q;
  assign err_long   = err_long_q;
  assign err_glitch = err_glitch_q;
  assign signal_ok  = signal_ok_q;

endmodule

// File: tb/tb_pwm_to_servo.sv
// Directed bench for pwm_to_servo with scaled-down timing parameters.
// code = min(255, floor((W - 100 + 2) / 4)) for W >= 100, else 0.
module tb_pwm_to_servo;

  localparam int unsigned P_MIN    = 100;
  localparam int unsigned P_STEP   = 4;
  localparam int unsigned P_MAX    = 1200;
  localparam int unsigned P_GLITCH = 50;
  localparam int unsigned P_TO     = 3000;
  localparam int          GAP      = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pwm_in = 1'b0;
  logic [7:0] servo_val;
  logic       valid, err_long, err_glitch, signal_ok;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int n_valid = 0, n_glitch = 0, n_long = 0;
  int last_valid_cyc = -1, last_glitch_cyc = -1, last_long_cyc = -1;

  typedef struct {
    int         width;
    bit         exp_valid;
    bit         exp_glitch;
    logic [7:0] exp_val;
  } vec_t;

  vec_t vecs[14];

  pwm_to_servo #(
    .PULSE_MIN     (P_MIN),
    .STEP_CLKS     (P_STEP),
    .PULSE_MAX     (P_MAX),
    .GLITCH_CLKS   (P_GLITCH),
    .FRAME_TIMEOUT (P_TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .servo_val  (servo_val),
    .valid      (valid),
    .err_long   (err_long),
    .err_glitch (err_glitch),
    .signal_ok  (signal_ok)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (valid)      begin n_valid++;  last_valid_cyc  = cyc; end
    if (err_glitch) begin n_glitch++; last_glitch_cyc = cyc; end
    if (err_long)   begin n_long++;   last_long_cyc   = cyc; end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_pulse(input string name, input int w, input bit exp_valid,
                          input bit exp_glitch, input int exp_val, output int rise_c);
    int nv0, ng0, nl0, fall_c;
    nv0 = n_valid; ng0 = n_glitch; nl0 = n_long;
    @(negedge clk);
    pwm_in = 1'b1;
    rise_c = cyc;
    repeat (w) @(negedge clk);
    pwm_in = 1'b0;
    fall_c = cyc;
    repeat (GAP) @(negedge clk);
    chk({name, " valid count"},  n_valid - nv0,  int'(exp_valid));
    chk({name, " glitch count"}, n_glitch - ng0, int'(exp_glitch));
    chk({name, " long count"},   n_long - nl0,   0);
    if (exp_valid)  chk({name, " valid timing"},  last_valid_cyc,  fall_c + 3);
    if (exp_glitch) chk({name, " glitch timing"}, last_glitch_cyc, fall_c + 3);
    chk({name, " servo_val"}, int'(servo_val), exp_val);
    chk({name, " signal_ok"}, int'(signal_ok), 1);
  endtask

  initial begin
    int  rc, nv0, ng0, nl0;
    bit  bad;

    vecs[0]  = '{100,  1'b1, 1'b0, 8'd0};
    vecs[1]  = '{610,  1'b1, 1'b0, 8'd128};
    vecs[2]  = '{1118, 1'b1, 1'b0, 8'd255};
    vecs[3]  = '{1117, 1'b1, 1'b0, 8'd254};
    vecs[4]  = '{102,  1'b1, 1'b0, 8'd1};
    vecs[5]  = '{101,  1'b1, 1'b0, 8'd0};
    vecs[6]  = '{200,  1'b1, 1'b0, 8'd25};
    vecs[7]  = '{1150, 1'b1, 1'b0, 8'd255};
    vecs[8]  = '{99,   1'b1, 1'b0, 8'd0};
    vecs[9]  = '{20,   1'b0, 1'b1, 8'd0};
    vecs[10] = '{50,   1'b1, 1'b0, 8'd0};
    vecs[11] = '{357,  1'b1, 1'b0, 8'd64};
    vecs[12] = '{49,   1'b0, 1'b1, 8'd64};
    vecs[13] = '{1200, 1'b1, 1'b0, 8'd255};

    // Reset held with the pin toggling: everything stays at zero
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      pwm_in = (i % 6) < 3;
      if ({servo_val, valid, err_long, err_glitch, signal_ok} != 12'd0) bad = 1'b1;
    end
    chk("reset outputs zero", int'(bad), 0);
    chk("reset strobes", n_valid + n_glitch + n_long, 0);

    // Release in the middle of a high pulse: that pulse is ignored
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (300) @(negedge clk);
    pwm_in = 1'b0;
    repeat (GAP) @(negedge clk);
    chk("partial pulse strobes", n_valid + n_glitch + n_long, 0);
    chk("partial pulse signal_ok", int'(signal_ok), 0);
    chk("partial pulse servo_val", int'(servo_val), 0);
    do_pulse("first good pulse", 610, 1'b1, 1'b0, 128, rc);

    // Table of single pulses
    for (int i = 0; i < 14; i++) begin
      do_pulse($sformatf("vec%0d w=%0d", i, vecs[i].width), vecs[i].width,
               vecs[i].exp_valid, vecs[i].exp_glitch, int'(vecs[i].exp_val), rc);
    end

    // Stuck high: err_long once hi_cnt hits PULSE_MAX, then resync
    nv0 = n_valid; ng0 = n_glitch; nl0 = n_long;
    @(negedge clk);
    pwm_in = 1'b1;
    rc = cyc;
    repeat (1500) @(negedge clk);
    pwm_in = 1'b0;
    repeat (GAP) @(negedge clk);
    chk("stuck high long count", n_long - nl0, 1);
    chk("stuck high long timing", last_long_cyc, rc + 1203);
    chk("stuck high no valid", n_valid - nv0, 0);
    chk("stuck high no glitch", n_glitch - ng0, 0);
    chk("stuck high servo_val held", int'(servo_val), 255);
    do_pulse("recover after long", 610, 1'b1, 1'b0, 128, rc);

    // Frame timeout: signal_ok drops exactly at FRAME_TIMEOUT, value held
    do_pulse("pre-timeout pulse", 610, 1'b1, 1'b0, 128, rc);
    while (cyc < rc + 3 + int'(P_TO)) @(negedge clk);
    chk("signal_ok before timeout", int'(signal_ok), 1);
    @(negedge clk);
    chk("signal_ok at timeout", int'(signal_ok), 0);
    chk("servo_val after timeout", int'(servo_val), 128);
    do_pulse("after timeout", 357, 1'b1, 1'b0, 64, rc);

    // Reset asserted mid-pulse: immediate clear, no strobe afterwards
    nv0 = n_valid; ng0 = n_glitch; nl0 = n_long;
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (300) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async reset outputs", int'({servo_val, valid, err_long, err_glitch, signal_ok}), 0);
    @(negedge clk);
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    chk("mid-pulse reset strobes", (n_valid - nv0) + (n_glitch - ng0) + (n_long - nl0), 0);
    chk("mid-pulse reset signal_ok", int'(signal_ok), 0);
    do_pulse("after mid-pulse reset", 610, 1'b1, 1'b0, 128, rc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
